tinyalu_cmd_ctrl: RTL and testbench



---
 rtl/tinyalu_cmd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tinyalu_cmd_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_cmd_ctrl.sv
// Generic FIFO: circular buffer with occupancy count; the head is visible combinationally.
// Latency: a push is visible at the head one edge later. Backpressure: the caller must not push when count == DEPTH.
module tinyalu_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Command front-end for one tinyalu: queues commands and runs start/done one command at a time.
// Latency: start rises one edge after a push into an empty FIFO. Backpressure: cmd_ready drops when full; rsp stalls the ALU.
module tinyalu_cmd_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [7:0]               alu_A,
  output logic [7:0]               alu_B,
  output logic [2:0]               alu_op,
  output logic                     alu_start,
  input  logic                     alu_done,
  input  logic [15:0]              alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_result,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic [7:0]               err_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] a;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  cmd_t          push_dat, head_dat;
  logic          push, pop, take_done, take_to, rsp_ack;
  logic [TW-1:0] timer;

  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign push_dat  = '{op: cmd_op, b: cmd_b, a: cmd_a};

  tinyalu_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    take_done = 1'b0;
    take_to   = 1'b0;
    rsp_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // done takes priority over a timeout expiring on the same edge
        if (alu_done) begin
          take_done = 1'b1;
          state_nxt = RESP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          take_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_ack   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      err_count   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (pop) begin
        alu_A     <= head_dat.a;
        alu_B     <= head_dat.b;
        alu_op    <= head_dat.op;
        alu_start <= 1'b1;
        timer     <= '0;
      end else if (state == BUSY) begin
        timer <= timer + TW'(1);
      end
      if (take_done || take_to) begin
        alu_start   <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_result  <= take_done ? alu_result : 16'h0000;
        rsp_timeout <= take_to;
      end
      if (take_to && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (rsp_ack) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tinyalu_cmd_ctrl.sv
// Directed bench for tinyalu_cmd_ctrl; the bench plays the role of the tinyalu.
module tb_tinyalu_cmd_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_timeout;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ta [5];
  logic [7:0]  tbv[5];
  logic [2:0]  top[5];
  logic [15:0] tr [5];

  always #5 clk = ~clk;

  tinyalu_cmd_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .fifo_count(fifo_count), .busy(busy), .err_count(err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_a  = a;
    cmd_b  = b;
    cmd_op = op;
  endtask

  initial begin
    int hi;
    ta[0] = 8'h01; tbv[0] = 8'h02; top[0] = 3'd1; tr[0] = 16'h0003;
    ta[1] = 8'h05; tbv[1] = 8'h03; top[1] = 3'd2; tr[1] = 16'h0001;
    ta[2] = 8'h0F; tbv[2] = 8'hF0; top[2] = 3'd3; tr[2] = 16'h00FF;
    ta[3] = 8'h10; tbv[3] = 8'h10; top[3] = 3'd4; tr[3] = 16'h0100;
    ta[4] = 8'hFF; tbv[4] = 8'h01; top[4] = 3'd1; tr[4] = 16'h0100;

    reset_n = 1'b0; cmd_valid = 1'b0; drive(8'h00, 8'h00, 3'd0);
    alu_done = 1'b0; alu_result = 16'h0000; rsp_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_count, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_A", alu_A, 0);
    step();
    reset_n = 1'b1;
    step();

    // single add, done after one start cycle
    cmd_valid = 1'b1; drive(8'h12, 8'h34, 3'd1);
    step();
    cmd_valid = 1'b0;
    chk("add_count_after_push", fifo_count, 1);
    chk("add_start_not_yet", alu_start, 0);
    step();
    chk("add_start_rise", alu_start, 1);
    chk("add_A", alu_A, 8'h12);
    chk("add_B", alu_B, 8'h34);
    chk("add_op", alu_op, 3'd1);
    chk("add_busy", busy, 1);
    chk("add_count_popped", fifo_count, 0);
    alu_done = 1'b1; alu_result = 16'h0046;
    step();
    alu_done = 1'b0;
    chk("add_start_fall", alu_start, 0);
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_result", rsp_result, 16'h0046);
    chk("add_rsp_timeout", rsp_timeout, 0);
    step();
    chk("add_rsp_hold", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    chk("add_rsp_consumed", rsp_valid, 0);
    chk("add_busy_clear", busy, 0);
    rsp_ready = 1'b0;

    // mul, done after three start cycles
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; drive(8'hFF, 8'hFF, 3'd4);
    step();
    cmd_valid = 1'b0; drive(8'h00, 8'h00, 3'd0);
    step();
    chk("mul_start", alu_start, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mul_start_hold", alu_start, 1);
      chk("mul_A_stable", alu_A, 8'hFF);
      chk("mul_B_stable", alu_B, 8'hFF);
      chk("mul_op_stable", alu_op, 3'd4);
    end
    alu_done = 1'b1; alu_result = 16'hFE01;
    step();
    alu_done = 1'b0;
    chk("mul_rsp_valid", rsp_valid, 1);
    chk("mul_rsp_result", rsp_result, 16'hFE01);
    chk("mul_start_fall", alu_start, 0);
    step();
    chk("mul_rsp_consumed", rsp_valid, 0);
    rsp_ready = 1'b0;

    // five back-to-back commands against a stalled response channel
    cmd_valid = 1'b1; drive(ta[0], tbv[0], top[0]);
    step();
    drive(ta[1], tbv[1], top[1]);
    step();
    drive(ta[2], tbv[2], top[2]);
    alu_done = 1'b1; alu_result = tr[0];
    step();
    alu_done = 1'b0;
    drive(ta[3], tbv[3], top[3]);
    step();
    chk("fill_ready_at_3", cmd_ready, 1);
    chk("fill_count_3", fifo_count, 3);
    drive(ta[4], tbv[4], top[4]);
    step();
    chk("fill_ready_full", cmd_ready, 0);
    chk("fill_count_4", fifo_count, 4);
    drive(8'hAA, 8'hBB, 3'd1);
    step();
    cmd_valid = 1'b0;
    chk("fill_no_push_full", fifo_count, 4);
    chk("fill_rsp_first", rsp_result, tr[0]);
    chk("fill_rsp_valid", rsp_valid, 1);
    chk("fill_one_op_only", alu_start, 0);
    rsp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("drain_rsp_dropped", rsp_valid, 0);
      chk("drain_start_low_idle", alu_start, 0);
      step();
      chk("drain_start", alu_start, 1);
      chk("drain_A", alu_A, ta[i]);
      chk("drain_B", alu_B, tbv[i]);
      chk("drain_op", alu_op, top[i]);
      chk("drain_count", fifo_count, 4 - i);
      alu_done = 1'b1; alu_result = tr[i];
      step();
      alu_done = 1'b0;
      chk("drain_rsp_valid", rsp_valid, 1);
      chk("drain_rsp_result", rsp_result, tr[i]);
      chk("drain_rsp_timeout", rsp_timeout, 0);
    end
    step();
    chk("drain_last_consumed", rsp_valid, 0);
    chk("drain_empty", fifo_count, 0);
    step();
    chk("drain_busy_clear", busy, 0);
    chk("drain_no_start", alu_start, 0);
    rsp_ready = 1'b0;

    // timeout: done never arrives
    cmd_valid = 1'b1; drive(8'h01, 8'h01, 3'd1);
    step();
    cmd_valid = 1'b0;
    step();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!alu_start) break;
      hi++;
      step();
    end
    chk("to_start_cycles", hi, 16);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_result", rsp_result, 16'h0000);
    chk("to_err_count", err_count, 1);
    step();
    alu_done = 1'b1; alu_result = 16'h1234;
    step();
    alu_done = 1'b0;
    step();
    chk("late_done_valid", rsp_valid, 1);
    chk("late_done_result", rsp_result, 16'h0000);
    chk("late_done_timeout", rsp_timeout, 1);
    chk("late_done_err", err_count, 1);
    chk("late_done_start", alu_start, 0);
    rsp_ready = 1'b1;
    step();
    chk("to_rsp_consumed", rsp_valid, 0);
    rsp_ready = 1'b0;

    // done coincides with the timeout edge
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; drive(8'hF0, 8'h3C, 3'd2);
    step();
    cmd_valid = 1'b0;
    step();
    repeat (15) step();
    chk("tie_start_16th", alu_start, 1);
    alu_done = 1'b1; alu_result = 16'h0030;
    step();
    alu_done = 1'b0;
    chk("tie_rsp_valid", rsp_valid, 1);
    chk("tie_rsp_timeout", rsp_timeout, 0);
    chk("tie_rsp_result", rsp_result, 16'h0030);
    chk("tie_err_unchanged", err_count, 1);
    step();
    chk("tie_rsp_consumed", rsp_valid, 0);
    rsp_ready = 1'b0;

    // reset while busy with three commands queued
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tbv[i], top[i]);
      step();
    end
    cmd_valid = 1'b0;
    chk("mid_count_3", fifo_count, 3);
    chk("mid_start_high", alu_start, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_start_async", alu_start, 0);
    chk("mid_rst_count_async", fifo_count, 0);
    chk("mid_rst_err_async", err_count, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err_count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle_start", alu_start, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
